vigna_bus_arbiter: RTL and testbench

- Two-master to one-slave memory arbiter downstream of the vigna core.
- Merges the core's instruction port (i_*) and data port (d_*) onto a single valid/ready memory port (m_*), so the core can run from one unified RAM or bus.
- Data requests win ties unless the previous grant went to data, which gives alternating fairness.
- An optional watchdog terminates hung memory transactions.

---
 rtl/vigna_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_vigna_bus_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vigna_bus_arbiter.sv
`timescale 1ns/1ps
// vigna_bus_arbiter: merges the vigna core's instruction and data ports onto one valid/ready memory port.
// Define VIGNA_ARB_TIMEOUT_EN to add a watchdog that terminates memory transactions stuck waiting for m_ready.
module vigna_bus_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t      state, state_next;
  grant_t      last_grant, last_grant_next;
  logic        m_valid_next;
  logic [31:0] m_addr_next;
  logic [31:0] m_wdata_next;
  logic [3:0]  m_wstrb_next;
  logic        busy;
  logic        timeout_hit;
  logic        complete;

  if (TIMEOUT_CYCLES == 16'd0) begin : g_timeout_range
    $error("vigna_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  assign busy     = (state == ST_BUSY_I) || (state == ST_BUSY_D);
  assign complete = busy && (m_ready || timeout_hit);

`ifdef VIGNA_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt, tmo_cnt_next;
  logic        bus_err_q, bus_err_next;

  // A real m_ready in the timeout cycle wins, so the watchdog only fires with m_ready low.
  assign timeout_hit = busy && !m_ready && (tmo_cnt == TIMEOUT_CYCLES);

  // Counter rests at zero in IDLE, so every grant starts counting from zero.
  always_comb begin
    tmo_cnt_next = tmo_cnt;
    bus_err_next = bus_err_q;
    if (!busy) begin
      tmo_cnt_next = 16'd0;
    end else if (!m_ready && !timeout_hit) begin
      tmo_cnt_next = tmo_cnt + 16'd1;
    end
    if (timeout_hit) begin
      bus_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt   <= 16'd0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt   <= tmo_cnt_next;
      bus_err_q <= bus_err_next;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // Data wins a tie unless it also won the previous grant.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    m_valid_next    = m_valid;
    m_addr_next     = m_addr;
    m_wdata_next    = m_wdata;
    m_wstrb_next    = m_wstrb;
    case (state)
      ST_IDLE: begin
        if (d_valid && (!i_valid || (last_grant == GRANT_I))) begin
          m_addr_next     = d_addr;
          m_wdata_next    = d_wdata;
          m_wstrb_next    = d_wstrb;
          m_valid_next    = 1'b1;
          last_grant_next = GRANT_D;
          state_next      = ST_BUSY_D;
        end else if (i_valid) begin
          m_addr_next     = i_addr;
          m_wdata_next    = 32'h0;
          m_wstrb_next    = 4'h0;
          m_valid_next    = 1'b1;
          last_grant_next = GRANT_I;
          state_next      = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (complete) begin
          m_valid_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        m_valid_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_I;
      m_valid    <= 1'b0;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
      m_wstrb    <= 4'h0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      m_valid    <= m_valid_next;
      m_addr     <= m_addr_next;
      m_wdata    <= m_wdata_next;
      m_wstrb    <= m_wstrb_next;
    end
  end

  // Completion is combinational; reset suppresses any pulse from an abandoned transaction.
  assign i_ready = resetn && (state == ST_BUSY_I) && complete;
  assign d_ready = resetn && (state == ST_BUSY_D) && complete;
  assign i_rdata = timeout_hit ? 32'h0 : m_rdata;
  assign d_rdata = timeout_hit ? 32'h0 : m_rdata;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
`timescale 1ns/1ps
// tb_vigna_bus_arbiter: directed self-checking bench for the vigna instruction/data memory arbiter.
module tb_vigna_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, i_ready, d_valid, d_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb, m_wstrb;
  logic        m_valid, m_ready, bus_err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  vigna_bus_arbiter #(.TIMEOUT_CYCLES(16'd4)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic do_reset();
    @(negedge clk);
    resetn  = 1'b0;
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
    i_addr  = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0; m_rdata = 32'h0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn  = 1'b0;
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
    i_addr  = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0; m_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== 69'h0) begin
      $display("[TB] FAIL reset_m_port: got valid=%b addr=%h wdata=%h wstrb=%h expected all zero",
               m_valid, m_addr, m_wdata, m_wstrb);
      errors++;
    end
    checks++;
    if ({i_ready, d_ready, bus_err} !== 3'b000) begin
      $display("[TB] FAIL reset_flags: got i_ready=%b d_ready=%b bus_err=%b expected 000", i_ready, d_ready, bus_err);
      errors++;
    end
    resetn = 1'b1;
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({i_ready, d_ready} !== 2'b00) begin
      $display("[TB] FAIL idle_m_ready: got i_ready=%b d_ready=%b expected 00", i_ready, d_ready);
      errors++;
    end
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      $display("[TB] FAIL idle_m_valid: got %b expected 0", m_valid);
      errors++;
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    i_valid = 1'b1;
    i_addr  = 32'h0000_0010;
    @(negedge clk);
    #1;
    checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h10, 32'h0, 4'h0}) begin
      $display("[TB] FAIL fetch_request: got valid=%b addr=%h wdata=%h wstrb=%h expected 1/00000010/00000000/0",
               m_valid, m_addr, m_wdata, m_wstrb);
      errors++;
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++;
      if ({m_valid, m_addr, i_ready, d_ready} !== {1'b1, 32'h10, 2'b00}) begin
        $display("[TB] FAIL fetch_hold: got valid=%b addr=%h i_ready=%b d_ready=%b expected 1/00000010/0/0",
                 m_valid, m_addr, i_ready, d_ready);
        errors++;
      end
    end
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'h0000_0093;
    #1;
    checks++;
    if ({i_ready, d_ready, i_rdata} !== {2'b10, 32'h93}) begin
      $display("[TB] FAIL fetch_response: got i_ready=%b d_ready=%b i_rdata=%h expected 1/0/00000093",
               i_ready, d_ready, i_rdata);
      errors++;
    end
    @(negedge clk);
    m_ready = 1'b0;
    i_valid = 1'b0;
    #1;
    checks++;
    if ({m_valid, i_ready} !== 2'b00) begin
      $display("[TB] FAIL fetch_release: got m_valid=%b i_ready=%b expected 0/0", m_valid, i_ready);
      errors++;
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    d_valid = 1'b1;
    d_addr  = 32'h0000_0100;
    d_wdata = 32'hCAFE_F00D;
    d_wstrb = 4'b0011;
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'h0BAD_0BAD;
    #1;
    checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h100, 32'hCAFE_F00D, 4'b0011}) begin
      $display("[TB] FAIL store_request: got valid=%b addr=%h wdata=%h wstrb=%b expected 1/00000100/cafef00d/0011",
               m_valid, m_addr, m_wdata, m_wstrb);
      errors++;
    end
    checks++;
    if ({d_ready, i_ready} !== 2'b10) begin
      $display("[TB] FAIL store_ready: got d_ready=%b i_ready=%b expected 1/0", d_ready, i_ready);
      errors++;
    end
    @(negedge clk);
    m_ready = 1'b0;
    d_valid = 1'b0;
    #1;
    checks++;
    if ({m_valid, d_ready, i_ready} !== 3'b000) begin
      $display("[TB] FAIL store_single_pulse: got m_valid=%b d_ready=%b i_ready=%b expected 000",
               m_valid, d_ready, i_ready);
      errors++;
    end
  endtask

  // Both masters request continuously; each completed master immediately issues its next request.
  task automatic test_back_to_back();
    int i_pulses = 0;
    int d_pulses = 0;
    logic exp_d;
    do_reset();
    @(negedge clk);
    i_valid = 1'b1; i_addr = 32'h0000_0200;
    d_valid = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'hA5A5_0000; d_wstrb = 4'hF;
    for (int g = 0; g < 4; g++) begin
      exp_d = (g % 2 == 0);
      @(negedge clk);
      m_ready = 1'b1;
      m_rdata = 32'h1000 + g;
      #1;
      checks++;
      if ({m_valid, m_addr, m_wdata, m_wstrb} !==
          {1'b1, exp_d ? d_addr : i_addr, exp_d ? d_wdata : 32'h0, exp_d ? d_wstrb : 4'h0}) begin
        $display("[TB] FAIL grant_%0d_fields: got valid=%b addr=%h wdata=%h wstrb=%h expected grant to %s",
                 g, m_valid, m_addr, m_wdata, m_wstrb, exp_d ? "D" : "I");
        errors++;
      end
      checks++;
      if ({d_ready, i_ready} !== {exp_d, !exp_d}) begin
        $display("[TB] FAIL grant_%0d_order: got d_ready=%b i_ready=%b expected %b/%b",
                 g, d_ready, i_ready, exp_d, !exp_d);
        errors++;
      end
      if (d_ready) d_pulses++;
      if (i_ready) i_pulses++;
      @(negedge clk);
      m_ready = 1'b0;
      #1;
      checks++;
      if ({m_valid, d_ready, i_ready} !== 3'b000) begin
        $display("[TB] FAIL gap_%0d: got m_valid=%b d_ready=%b i_ready=%b expected 000",
                 g, m_valid, d_ready, i_ready);
        errors++;
      end
      if (exp_d) begin
        d_addr  = d_addr + 32'h4;
        d_wdata = d_wdata + 32'h1;
      end else begin
        i_addr = i_addr + 32'h4;
      end
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    checks++;
    if ((d_pulses != 2) || (i_pulses != 2)) begin
      $display("[TB] FAIL pulse_count: got d=%0d i=%0d expected d=2 i=2", d_pulses, i_pulses);
      errors++;
    end
  endtask

  task automatic test_reset_mid_transaction();
    @(negedge clk);
    d_valid = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'h5555_AAAA; d_wstrb = 4'hF;
    @(negedge clk);
    #1;
    checks++;
    if ({m_valid, m_addr} !== {1'b1, 32'h400}) begin
      $display("[TB] FAIL abort_busy: got m_valid=%b m_addr=%h expected 1/00000400", m_valid, m_addr);
      errors++;
    end
    resetn  = 1'b0;
    d_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({m_valid, m_addr, d_ready} !== {1'b0, 32'h0, 1'b0}) begin
      $display("[TB] FAIL abort_reset: got m_valid=%b m_addr=%h d_ready=%b expected 0/00000000/0",
               m_valid, m_addr, d_ready);
      errors++;
    end
    resetn  = 1'b1;
    i_valid = 1'b1;
    i_addr  = 32'h0000_0020;
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'h0000_0013;
    #1;
    checks++;
    if ({m_addr, i_ready, d_ready, i_rdata} !== {32'h20, 2'b10, 32'h13}) begin
      $display("[TB] FAIL abort_recover: got m_addr=%h i_ready=%b d_ready=%b i_rdata=%h expected 00000020/1/0/00000013",
               m_addr, i_ready, d_ready, i_rdata);
      errors++;
    end
    @(negedge clk);
    m_ready = 1'b0;
    i_valid = 1'b0;
  endtask

`ifdef VIGNA_ARB_TIMEOUT_EN
  // TIMEOUT_CYCLES=4: the forced completion lands four cycles after m_valid rises.
  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    d_valid = 1'b1; d_addr = 32'h0000_0500; d_wstrb = 4'h0; m_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({m_valid, d_ready, bus_err} !== 3'b100) begin
        $display("[TB] FAIL timeout_wait_%0d: got m_valid=%b d_ready=%b bus_err=%b expected 1/0/0",
                 c, m_valid, d_ready, bus_err);
        errors++;
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, 32'h0}) begin
      $display("[TB] FAIL timeout_fire: got d_ready=%b d_rdata=%h expected 1/00000000", d_ready, d_rdata);
      errors++;
    end
    @(negedge clk);
    d_valid = 1'b0;
    #1;
    checks++;
    if ({m_valid, bus_err} !== 2'b01) begin
      $display("[TB] FAIL timeout_err: got m_valid=%b bus_err=%b expected 0/1", m_valid, bus_err);
      errors++;
    end
    i_valid = 1'b1; i_addr = 32'h0000_0040;
    @(negedge clk);
    m_ready = 1'b1; m_rdata = 32'h0000_0077;
    #1;
    checks++;
    if ({i_ready, i_rdata, bus_err} !== {1'b1, 32'h77, 1'b1}) begin
      $display("[TB] FAIL timeout_sticky: got i_ready=%b i_rdata=%h bus_err=%b expected 1/00000077/1",
               i_ready, i_rdata, bus_err);
      errors++;
    end
    @(negedge clk);
    m_ready = 1'b0; i_valid = 1'b0;
    do_reset();
    @(negedge clk);
    d_valid = 1'b1; d_addr = 32'h0000_0600;
    repeat (5) @(negedge clk);
    m_ready = 1'b1; m_rdata = 32'h0000_0055;
    #1;
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, 32'h55}) begin
      $display("[TB] FAIL timeout_race_data: got d_ready=%b d_rdata=%h expected 1/00000055", d_ready, d_rdata);
      errors++;
    end
    @(negedge clk);
    m_ready = 1'b0; d_valid = 1'b0;
    #1;
    checks++;
    if ({m_valid, bus_err} !== 2'b00) begin
      $display("[TB] FAIL timeout_race_err: got m_valid=%b bus_err=%b expected 0/0", m_valid, bus_err);
      errors++;
    end
  endtask
`else
  // Without the watchdog a transaction must wait well beyond any timeout value.
  task automatic test_no_timeout();
    int early = 0;
    do_reset();
    @(negedge clk);
    d_valid = 1'b1; d_addr = 32'h0000_0700; d_wstrb = 4'h0; m_rdata = 32'hDEAD_BEEF;
    repeat (300) begin
      @(negedge clk);
      #1;
      if ({m_valid, d_ready, bus_err} !== 3'b100) early++;
    end
    checks++;
    if (early != 0) begin
      $display("[TB] FAIL no_timeout_wait: got %0d bad cycles expected 0", early);
      errors++;
    end
    m_ready = 1'b1; m_rdata = 32'h0000_0099;
    #1;
    checks++;
    if ({d_ready, d_rdata, bus_err} !== {1'b1, 32'h99, 1'b0}) begin
      $display("[TB] FAIL no_timeout_done: got d_ready=%b d_rdata=%h bus_err=%b expected 1/00000099/0",
               d_ready, d_rdata, bus_err);
      errors++;
    end
    @(negedge clk);
    m_ready = 1'b0; d_valid = 1'b0;
  endtask
`endif

  initial begin
    resetn = 1'b0;
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0; m_rdata = 32'h0;
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_reset_mid_transaction();
`ifdef VIGNA_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
